pipe_ctrl: RTL and testbench
============================

# pipe_ctrl

Central pipeline sequencer for the rv32 five-stage core. It sits beside the operand hazard manager and turns stage-level events into per-stage register enables, bubble-insert flushes and a PC redirect select. The events are a load-use stall request, a taken branch or jump resolved in execute, a data-memory wait and a halt request. It also keeps a saturating stall-cycle counter and raises a sticky error on a data-memory timeout.

## Interface
Parameters:
- MEM_TIMEOUT, 15: maximum MEM_WAIT cycles without dmem_ack before the error is raised (range 1..255).
- CNT_W, 16: width of stall_cnt.

Ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-low reset (asserted when 0).
- hazard_stall  in  1  load-use stall request from the operand hazard manager.
- redirect  in  1  taken branch/JAL/JALR resolved in execute; held by execute while execute is frozen.
- dmem_req  in  1  access-stage load/store issued this cycle.
- dmem_ack  in  1  data memory completes the access this cycle.
- halt_req  in  1  ECALL/EBREAK decoded in execute.
- en_fe, en_de, en_exe, en_acc  out  1 each  stage pipeline-register enables.
- flush_de  out  1  decode register loads NOP (0x00000013) instead of its input.
- flush_exe  out  1  execute register loads NOP.
- pc_sel  out  1  1 selects the redirect target as next PC.
- halted  out  1  core is in the HALT state.
- err  out  1  sticky data-memory timeout.
- stall_cnt  out  CNT_W  saturating count of stall cycles.

## Operation
- State register: RUN, LD_STALL, MEM_WAIT, HALT. Outputs are Mealy: they decode from the registered state plus the current inputs.
- While rst=0, all outputs are forced to 0, regardless of state.
- RUN, evaluated in priority order:
  - Memory freeze: dmem_req=1 and dmem_ack=0 -> all en=0, no flush, pc_sel=0. Next state MEM_WAIT, wait_cnt=1.
  - Redirect: redirect=1 -> all en=1, flush_de=1, flush_exe=1, pc_sel=1. Stay in RUN. A simultaneous hazard_stall or halt_req is dropped, because the instructions that raised them are flushed.
  - Load-use stall: hazard_stall=1 -> en_fe=0, en_de=0, en_exe=1, en_acc=1, flush_exe=1 (one bubble). Next state LD_STALL.
  - Halt: halt_req=1 -> en_fe=0, en_de=0, flush_exe=1, en_exe=1, en_acc=1 so older instructions drain one stage. Next state HALT.
  - Otherwise all en=1, flush=0, pc_sel=0.
- LD_STALL lasts exactly one cycle. Behaves like RUN except hazard_stall is ignored, which guarantees forward progress. Next state RUN, or MEM_WAIT if the memory-freeze condition holds.
- MEM_WAIT:
  - All en=0. redirect, hazard_stall and halt_req are ignored; their sources are frozen.
  - On dmem_ack=1: all en=1, flush=0. Next state RUN. A redirect still held is acted on in the following RUN cycle.
  - On dmem_ack=0 with wait_cnt==MEM_TIMEOUT: err is set (sticky). Next state HALT.
  - On dmem_ack=0 otherwise: wait_cnt increments (8-bit).
- HALT: all en=0, flush=0, pc_sel=0, halted=1. Only reset exits HALT.
- stall_cnt increments on every cycle where en_fe=0 and state is not HALT. It saturates at all-ones and never wraps.

## Timing
- Reset values: state=RUN, wait_cnt=0, err=0, stall_cnt=0. All outputs are 0 while rst=0.
- Deassertion of rst is synchronised externally. The first cycle after release is ordinary RUN.
- Zero-cycle latency from inputs to enables, flushes and pc_sel (combinational decode of the registered state). State, err, wait_cnt and stall_cnt update on the rising edge.
- Load-use costs exactly one bubble cycle. Redirect costs two flushed slots and no extra cycles.
- A memory access that is acked in its issue cycle costs zero cycles. An access acked k cycles after issue costs k frozen cycles.
- Timeout: err and halted rise at the edge that ends the MEM_TIMEOUT-th MEM_WAIT cycle without ack.
- Reset asserted mid-operation, including during MEM_WAIT or HALT, immediately forces outputs to 0 and returns the state to RUN.

## Test plan
- Load-use: in RUN, assert hazard_stall for 2 cycles -> cycle 0: en_fe=en_de=0 and flush_exe=1; cycle 1 (LD_STALL): all en=1 with hazard_stall still 1; stall_cnt=1.
- Redirect plus stall together: redirect=1, hazard_stall=1, halt_req=1 in the same cycle -> pc_sel=1, flush_de=flush_exe=1, all en=1, state stays RUN, stall_cnt unchanged.
- Memory wait: dmem_req=1, dmem_ack=0 for 3 cycles, then ack -> en all 0 for 3 cycles, all 1 on the ack cycle, stall_cnt=3, err=0.
- Timeout with MEM_TIMEOUT=4: hold dmem_req=1 with no ack -> err=1 and halted=1 from cycle 5 on, all en=0. Only rst=0 clears them.
- Halt: halt_req=1 in RUN -> one cycle with en_fe=en_de=0 and flush_exe=1, then halted=1 with all en=0 indefinitely.
- Saturation and reset: CNT_W=4, hold stalls for 20 cycles -> stall_cnt=15. Pulse rst=0 mid-MEM_WAIT -> stall_cnt=0, state RUN, all outputs 0 while reset is held.

Source files
------------

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer for the rv32 five-stage core: turns stall/redirect/memory/halt
// events into per-stage enables, bubble flushes and PC select.
//
// state    | meaning
// ---------+----------------------------------------------------------
// RUN      | normal issue, events decoded in priority order
// LD_STALL | single bubble cycle after a load-use stall, stall ignored
// MEM_WAIT | pipeline frozen until dmem_ack or timeout
// HALT     | pipeline stopped, left only by reset
module pipe_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hazard_stall,
  input  logic             redirect,
  input  logic             dmem_req,
  input  logic             dmem_ack,
  input  logic             halt_req,
  output logic             en_fe,
  output logic             en_de,
  output logic             en_exe,
  output logic             en_acc,
  output logic             flush_de,
  output logic             flush_exe,
  output logic             pc_sel,
  output logic             halted,
  output logic             err,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {RUN, LD_STALL, MEM_WAIT, HALT} state_t;

  localparam logic [7:0] TIMEOUT_C = 8'(MEM_TIMEOUT);

  state_t           state, state_nxt;
  logic [7:0]       wait_cnt, wait_nxt;
  logic             err_q, err_nxt;
  logic [CNT_W-1:0] stall_q;
  logic             fe_r, de_r, exe_r, acc_r, fde_r, fex_r, pcs_r;

  always_comb begin
    fe_r      = 1'b0;
    de_r      = 1'b0;
    exe_r     = 1'b0;
    acc_r     = 1'b0;
    fde_r     = 1'b0;
    fex_r     = 1'b0;
    pcs_r     = 1'b0;
    state_nxt = state;
    wait_nxt  = wait_cnt;
    err_nxt   = err_q;
    case (state)
      RUN, LD_STALL: begin
        if (dmem_req && !dmem_ack) begin
          state_nxt = MEM_WAIT;
          wait_nxt  = 8'd1;
        end else if (redirect) begin
          {fe_r, de_r, exe_r, acc_r} = 4'b1111;
          {fde_r, fex_r, pcs_r}      = 3'b111;
          state_nxt = RUN;
        end else if (hazard_stall && state == RUN) begin
          {exe_r, acc_r} = 2'b11;
          fex_r     = 1'b1;
          state_nxt = LD_STALL;
        end else if (halt_req) begin
          // let older instructions drain one stage before stopping
          {exe_r, acc_r} = 2'b11;
          fex_r     = 1'b1;
          state_nxt = HALT;
        end else begin
          {fe_r, de_r, exe_r, acc_r} = 4'b1111;
          state_nxt = RUN;
        end
      end
      MEM_WAIT: begin
        if (dmem_ack) begin
          {fe_r, de_r, exe_r, acc_r} = 4'b1111;
          state_nxt = RUN;
        end else if (wait_cnt == TIMEOUT_C) begin
          err_nxt   = 1'b1;
          state_nxt = HALT;
        end else begin
          wait_nxt = wait_cnt + 8'd1;
        end
      end
      HALT:    state_nxt = HALT;
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= RUN;
      wait_cnt <= 8'd0;
      err_q    <= 1'b0;
      stall_q  <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
      err_q    <= err_nxt;
      if (!fe_r && state != HALT && stall_q != '1)
        stall_q <= stall_q + CNT_W'(1);
    end
  end

  // outputs are held low while reset is asserted, whatever the inputs do
  assign en_fe     = rst & fe_r;
  assign en_de     = rst & de_r;
  assign en_exe    = rst & exe_r;
  assign en_acc    = rst & acc_r;
  assign flush_de  = rst & fde_r;
  assign flush_exe = rst & fex_r;
  assign pc_sel    = rst & pcs_r;
  assign halted    = rst & (state == HALT);
  assign err       = rst & err_q;
  assign stall_cnt = rst ? stall_q : '0;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: driver pushes hand-computed expectations per
// cycle, a negedge monitor pops and compares against the DUT outputs.
module tb_pipe_ctrl;

  localparam int CW = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic hazard_stall = 1'b0, redirect = 1'b0, dmem_req = 1'b0, dmem_ack = 1'b0, halt_req = 1'b0;
  logic en_fe, en_de, en_exe, en_acc, flush_de, flush_exe, pc_sel, halted, err;
  logic [CW-1:0] stall_cnt;

  pipe_ctrl #(.MEM_TIMEOUT(4), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .hazard_stall(hazard_stall), .redirect(redirect),
    .dmem_req(dmem_req), .dmem_ack(dmem_ack), .halt_req(halt_req),
    .en_fe(en_fe), .en_de(en_de), .en_exe(en_exe), .en_acc(en_acc),
    .flush_de(flush_de), .flush_exe(flush_exe), .pc_sel(pc_sel),
    .halted(halted), .err(err), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  // {en_fe,en_de,en_exe,en_acc,flush_de,flush_exe,pc_sel,halted,err}
  localparam logic [8:0] ALL1 = 9'b1111_000_00;
  localparam logic [8:0] ALL0 = 9'b0000_000_00;
  localparam logic [8:0] BUBL = 9'b0011_010_00;
  localparam logic [8:0] REDR = 9'b1111_111_00;
  localparam logic [8:0] HLT  = 9'b0000_000_10;
  localparam logic [8:0] TOUT = 9'b0000_000_11;

  typedef struct {
    string         name;
    logic [8:0]    flags;
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int failures = 0;

  // inputs: {rst, hazard_stall, redirect, dmem_req, dmem_ack, halt_req}
  task automatic step(input string name, input logic [5:0] in, input logic [8:0] f,
                      input logic [CW-1:0] c);
    exp_t e;
    @(posedge clk);
    #1;
    {rst, hazard_stall, redirect, dmem_req, dmem_ack, halt_req} = in;
    e.name = name;
    e.flags = f;
    e.cnt = c;
    q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      logic [8:0] got;
      e = q.pop_front();
      got = {en_fe, en_de, en_exe, en_acc, flush_de, flush_exe, pc_sel, halted, err};
      checks++;
      if (got !== e.flags || stall_cnt !== e.cnt) begin
        failures++;
        $display("FAIL %s: got flags=%b cnt=%0d, expected flags=%b cnt=%0d",
                 e.name, got, stall_cnt, e.flags, e.cnt);
      end
    end
  end

  initial begin
    step("rst_gate0",   6'b011000, ALL0, 0);
    step("rst_gate1",   6'b001101, ALL0, 0);
    step("run_idle",    6'b100000, ALL1, 0);
    step("lu_bubble",   6'b110000, BUBL, 0);
    step("lu_ldstall",  6'b110000, ALL1, 1);
    step("lu_after",    6'b100000, ALL1, 1);
    step("redir_all",   6'b111001, REDR, 1);
    step("redir_after", 6'b100000, ALL1, 1);
    step("mw_issue",    6'b100100, ALL0, 1);
    step("mw_w1",       6'b100100, ALL0, 2);
    step("mw_w2",       6'b100100, ALL0, 3);
    step("mw_ack",      6'b100110, ALL1, 4);
    step("mw_after",    6'b100000, ALL1, 4);
    step("ack_same",    6'b100110, ALL1, 4);
    step("ack_after",   6'b100000, ALL1, 4);
    step("ls_bubble",   6'b110000, BUBL, 4);
    step("ls_freeze",   6'b110100, ALL0, 5);
    step("mw_ign_red",  6'b101010, ALL1, 6);
    step("red_held",    6'b101000, REDR, 6);
    step("red_done",    6'b100000, ALL1, 6);
    step("rstmw_iss",   6'b100100, ALL0, 6);
    step("rstmw_w1",    6'b100100, ALL0, 7);
    step("rstmw_rst",   6'b010100, ALL0, 0);
    step("rstmw_run",   6'b100000, ALL1, 0);
    step("to_issue",    6'b100100, ALL0, 0);
    step("to_w1",       6'b100100, ALL0, 1);
    step("to_w2",       6'b100100, ALL0, 2);
    step("to_w3",       6'b100100, ALL0, 3);
    step("to_w4",       6'b100100, ALL0, 4);
    step("to_err",      6'b111111, TOUT, 5);
    step("to_sticky",   6'b100000, TOUT, 5);
    step("to_rst",      6'b000000, ALL0, 0);
    step("to_clear",    6'b100000, ALL1, 0);
    step("halt_drain",  6'b100001, BUBL, 0);
    step("halt_hold",   6'b101000, HLT,  1);
    step("halt_hold2",  6'b100110, HLT,  1);
    step("halt_rst",    6'b000000, ALL0, 0);
    step("halt_exit",   6'b100000, ALL1, 0);
    // four frozen cycles per access, acked just before timeout: 20 stalls total
    for (int g = 0; g < 5; g++) begin
      for (int i = 0; i < 4; i++) begin
        int n;
        n = (4 * g + i > 15) ? 15 : 4 * g + i;
        step("sat_frozen", 6'b100100, ALL0, CW'(n));
      end
      step("sat_ack", 6'b100110, ALL1, CW'((4 * g + 4 > 15) ? 15 : 4 * g + 4));
    end
    step("sat_final", 6'b100000, ALL1, 15);

    for (int k = 0; k < 10 && q.size() > 0; k++) @(posedge clk);
    if (q.size() > 0) begin
      failures++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
